// File: rtl/data_mux_n_1_if.sv
// data_mux_n_1_if
// Handshake bundle for the registered N:1 data multiplexer.
//   in_data   : packed channel words, channel k in bits [k*DATA_WL-1 -: DATA_WL]
//   in_valid  : per-channel valid (bit k-1 = channel k)
//   in_ready  : per-channel ready, one-hot or zero
//   sel       : direct-mode channel code, 0 = none
//   mode      : 0 = direct, 1 = round-robin
//   out_data  : registered selected word
//   out_valid : out_data holds an untaken word
//   out_ready : consumer accepts the word
//   out_src   : channel code of the word in out_data
// master = producer/consumer side, slave = multiplexer side.
interface data_mux_n_1_if #(
    parameter int DATA_WL = 16,
    parameter int N_IN    = 3,
    parameter int SEL_WL  = $clog2(N_IN + 1)
);
    logic [N_IN*DATA_WL-1:0] in_data;
    logic [N_IN-1:0]         in_valid;
    logic [N_IN-1:0]         in_ready;
    logic [SEL_WL-1:0]       sel;
    logic                    mode;
    logic [DATA_WL-1:0]      out_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [SEL_WL-1:0]       out_src;

    modport master (
        output in_data, in_valid, sel, mode, out_ready,
        input  in_ready, out_data, out_valid, out_src
    );

    modport slave (
        input  in_data, in_valid, sel, mode, out_ready,
        output in_ready, out_data, out_valid, out_src
    );
endinterface

// File: rtl/data_mux_n_1.sv
// data_mux_n_1
// Registered N:1 multiplexer with valid/ready on every input channel and on
// the output. Direct mode picks the channel named by sel; round-robin mode
// arbitrates among valid channels starting after the last granted one.
// Ports:
//   clk : clock, rising edge
//   rst : asynchronous, active-high reset
//   bus : data_mux_n_1_if.slave (channel inputs, sel/mode, registered output)
module data_mux_n_1 #(
    parameter int DATA_WL = 16,
    parameter int N_IN    = 3
) (
    input  logic           clk,
    input  logic           rst,
    data_mux_n_1_if.slave  bus
);
    localparam int SEL_WL = $clog2(N_IN + 1);

    logic [DATA_WL-1:0] out_data_q;
    logic               out_valid_q;
    logic [SEL_WL-1:0]  out_src_q;
    logic [SEL_WL-1:0]  rr_ptr;

    logic [SEL_WL-1:0]  gnt;
    logic [SEL_WL-1:0]  gnt_direct;
    logic [SEL_WL-1:0]  gnt_above;
    logic [SEL_WL-1:0]  gnt_lowest;
    logic [DATA_WL-1:0] gnt_word;
    logic [N_IN-1:0]    ready;
    logic               space;
    logic               xfer_in;

    assign space   = !out_valid_q || bus.out_ready;
    assign xfer_in = (gnt != '0) && space && !rst;

    // Round-robin: the lowest valid channel above rr_ptr wins; if none lies
    // above the pointer, wrap to the lowest valid channel overall.
    always_comb begin
        gnt_direct = '0;
        gnt_above  = '0;
        gnt_lowest = '0;
        for (int k = N_IN; k >= 1; k--) begin
            if (bus.in_valid[k-1]) begin
                gnt_lowest = SEL_WL'(k);
                if (SEL_WL'(k) > rr_ptr) begin
                    gnt_above = SEL_WL'(k);
                end
                if (bus.sel == SEL_WL'(k)) begin
                    gnt_direct = SEL_WL'(k);
                end
            end
        end
        if (bus.mode) begin
            gnt = (gnt_above != '0) ? gnt_above : gnt_lowest;
        end else begin
            gnt = gnt_direct;
        end
    end

    always_comb begin
        gnt_word = '0;
        ready    = '0;
        for (int k = 1; k <= N_IN; k++) begin
            if (gnt == SEL_WL'(k)) begin
                gnt_word   = bus.in_data[(k-1)*DATA_WL +: DATA_WL];
                ready[k-1] = space && !rst;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_src_q   <= '0;
            rr_ptr      <= SEL_WL'(N_IN);
        end else if (xfer_in) begin
            // Also covers the simultaneous in/out case: word replaced in place.
            out_data_q  <= gnt_word;
            out_src_q   <= gnt;
            out_valid_q <= 1'b1;
            rr_ptr      <= gnt;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.in_ready  = ready;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_src   = out_src_q;
endmodule
